// File: rtl/mem_map_pkg.sv
// mem_map_pkg: data-side address map shared by the core and benches.
// Region codes classify each load/store address.
package mem_map_pkg;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam int unsigned RAM_WORDS = 256;
  localparam logic [31:0] OUT_ADDR  = 32'h0000_0400;
  localparam logic [31:0] CNT_ADDR  = 32'h0000_0404;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_OUT,
    RGN_CNT,
    RGN_NONE
  } region_e;

endpackage

// File: rtl/data_mem_ctrl_ram.sv
// data_ram: single-port synchronous RAM, registered read data.
// A read and write on the same edge returns the old word.
module data_ram #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Store on write, capture the pre-write word on read.
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store responder with RAM, output reg and counter.
// Define DATA_MEM_CNT_EN to include the cycle counter at CNT_ADDR.
module data_mem_ctrl #(
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [31:0] OUT_ADDR  = 32'h0000_0400,
  parameter logic [31:0] CNT_ADDR  = 32'h0000_0404
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic [15:0] data_out
);

  import mem_map_pkg::*;

  localparam int unsigned AW = $clog2(RAM_WORDS);

`ifdef DATA_MEM_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  region_e     rgn;
  region_e     rsel_q;
  logic [31:0] aux_q;
  logic [31:0] ram_q;
  logic [31:0] cnt_q;
  logic [31:0] aux_d;
  logic        ram_we;
  logic        ram_re;
  logic        in_ram;
  logic        is_out;
  logic        is_cnt;

  assign in_ram = {2'b00, addr[31:2]} < 32'(RAM_WORDS);
  assign is_out = addr[31:2] == OUT_ADDR[31:2];
  assign is_cnt = addr[31:2] == CNT_ADDR[31:2];

  // Address decode into one region.
  always_comb begin
    rgn = RGN_NONE;
    unique case (1'b1)
      in_ram:          rgn = RGN_RAM;
      is_out:          rgn = RGN_OUT;
      is_cnt && CNT_ON: rgn = RGN_CNT;
      default:         rgn = RGN_NONE;
    endcase
  end

  assign ram_we = we && (rgn == RGN_RAM);
  assign ram_re = re && !rst && (rgn == RGN_RAM);

  data_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr[AW+1:2]),
    .wdata (wdata),
    .rdata (ram_q)
  );

  // Board output register, low half of the store data.
  always_ff @(posedge clk) begin
    if (rst)
      data_out <= '0;
    else if (we && (rgn == RGN_OUT))
      data_out <= wdata[15:0];
  end

`ifdef DATA_MEM_CNT_EN
  // Free-running cycle counter, loadable by a store.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (we && (rgn == RGN_CNT))
      cnt_q <= wdata;
    else
      cnt_q <= cnt_q + 32'd1;
  end
`else
  logic unused_wdata_hi;

  assign cnt_q = '0;
  assign unused_wdata_hi = ^wdata[31:16];
`endif

  // Non-RAM read data, sampled before any same-edge write.
  always_comb begin
    aux_d = '0;
    unique case (rgn)
      RGN_OUT: aux_d = {16'h0000, data_out};
      RGN_CNT: aux_d = cnt_q;
      default: aux_d = '0;
    endcase
  end

  // Single response stage: valid, error and source select.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rsel_q <= RGN_NONE;
      aux_q  <= '0;
    end else begin
      rvalid <= re;
      err    <= (re || we) && (rgn == RGN_NONE);
      if (re) begin
        rsel_q <= rgn;
        aux_q  <= aux_d;
      end
    end
  end

  assign rdata = (rsel_q == RGN_RAM) ? ram_q : aux_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vector bench for data_mem_ctrl.
// Each vector is one request cycle; outputs checked just after its edge.
module tb_data_mem_ctrl;

  import mem_map_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic [15:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic        r;
    logic        ev;
    logic [31:0] er;
    logic        ee;
    logic [15:0] eo;
  } vec_t;

  vec_t tv[$];

  data_mem_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .err      (err),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic [31:0] a, logic [31:0] d, logic w, logic r,
    logic ev, logic [31:0] er, logic ee, logic [15:0] eo);
    vec_t t;
    t.a = a; t.d = d; t.w = w; t.r = r;
    t.ev = ev; t.er = er; t.ee = ee; t.eo = eo;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] d,
                       logic w, logic r, logic rs);
    addr  = a;
    wdata = d;
    we    = w;
    re    = r;
    rst   = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst rdata", rdata, 32'h0);
    chk("rst rvalid", 32'(rvalid), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    chk("rst data_out", 32'(data_out), 32'h0);

    tv.push_back(mk(32'h0, 32'h1111_1111, 1, 0, 0, 32'h0, 0, 16'h0));
    tv.push_back(mk(32'h10, 32'hDEAD_BEEF, 1, 0, 0, 32'h0, 0, 16'h0));
    tv.push_back(mk(32'h10, 32'h0, 0, 1, 1, 32'hDEAD_BEEF, 0, 16'h0));
    tv.push_back(mk(32'h0, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 0, 16'h0));
    tv.push_back(mk(OUT_ADDR, 32'h1234_ABCD, 1, 0,
                    0, 32'hDEAD_BEEF, 0, 16'hABCD));
    tv.push_back(mk(OUT_ADDR, 32'h0, 0, 1, 1, 32'h0000_ABCD, 0, 16'hABCD));
    tv.push_back(mk(32'h20, 32'h1, 1, 0, 0, 32'h0000_ABCD, 0, 16'hABCD));
    tv.push_back(mk(32'h20, 32'h2, 1, 1, 1, 32'h1, 0, 16'hABCD));
    tv.push_back(mk(32'h20, 32'h0, 0, 1, 1, 32'h2, 0, 16'hABCD));
    tv.push_back(mk(32'h800, 32'h0, 0, 1, 1, 32'h0, 1, 16'hABCD));
    tv.push_back(mk(32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 16'hABCD));
    tv.push_back(mk(32'h800, 32'h5555_5555, 1, 0, 0, 32'h0, 1, 16'hABCD));
    tv.push_back(mk(32'h0, 32'h0, 0, 1, 1, 32'h1111_1111, 0, 16'hABCD));
    tv.push_back(mk(32'h10, 32'h0, 0, 1, 1, 32'hDEAD_BEEF, 0, 16'hABCD));
    tv.push_back(mk(OUT_ADDR, 32'h0000_5678, 1, 1,
                    1, 32'h0000_ABCD, 0, 16'h5678));
    tv.push_back(mk(OUT_ADDR, 32'h0, 0, 1, 1, 32'h0000_5678, 0, 16'h5678));
    tv.push_back(mk(32'h13, 32'h0, 0, 1, 1, 32'hDEAD_BEEF, 0, 16'h5678));
    tv.push_back(mk(32'h22, 32'h0, 0, 1, 1, 32'h2, 0, 16'h5678));
    tv.push_back(mk(32'h3FC, 32'hAAAA_5555, 1, 0, 0, 32'h2, 0, 16'h5678));
    tv.push_back(mk(32'h3FC, 32'h0, 0, 1, 1, 32'hAAAA_5555, 0, 16'h5678));
    tv.push_back(mk(32'h408, 32'h0, 0, 1, 1, 32'h0, 1, 16'h5678));
    tv.push_back(mk(32'h800, 32'h1, 1, 1, 1, 32'h0, 1, 16'h5678));
    tv.push_back(mk(32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 16'h5678));
    tv.push_back(mk(32'hFFFF_FFF0, 32'h0, 0, 1, 1, 32'h0, 1, 16'h5678));
`ifdef DATA_MEM_CNT_EN
    tv.push_back(mk(CNT_ADDR, 32'hFFFF_FFFE, 1, 0, 0, 32'h0, 0, 16'h5678));
    tv.push_back(mk(CNT_ADDR, 32'h0, 0, 1, 1, 32'hFFFF_FFFE, 0, 16'h5678));
    tv.push_back(mk(CNT_ADDR, 32'h0, 0, 1, 1, 32'hFFFF_FFFF, 0, 16'h5678));
    tv.push_back(mk(CNT_ADDR, 32'h0, 0, 1, 1, 32'h0, 0, 16'h5678));
    tv.push_back(mk(CNT_ADDR, 32'h7, 1, 1, 1, 32'h1, 0, 16'h5678));
    tv.push_back(mk(CNT_ADDR, 32'h0, 0, 1, 1, 32'h7, 0, 16'h5678));
`else
    tv.push_back(mk(CNT_ADDR, 32'h0, 0, 1, 1, 32'h0, 1, 16'h5678));
    tv.push_back(mk(CNT_ADDR, 32'h9, 1, 0, 0, 32'h0, 1, 16'h5678));
    tv.push_back(mk(OUT_ADDR, 32'h0, 0, 1, 1, 32'h0000_5678, 0, 16'h5678));
`endif

    foreach (tv[i]) begin
      drive(tv[i].a, tv[i].d, tv[i].w, tv[i].r, 1'b0);
      chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(tv[i].ev));
      chk($sformatf("v%0d rdata", i), rdata, tv[i].er);
      chk($sformatf("v%0d err", i), 32'(err), 32'(tv[i].ee));
      chk($sformatf("v%0d data_out", i), 32'(data_out), 32'(tv[i].eo));
    end

    drive(OUT_ADDR, 32'h0000_00FF, 1, 0, 0);
    chk("pre-rst data_out", 32'(data_out), 32'h00FF);
    drive(OUT_ADDR, 32'h0000_FFFF, 1, 1, 1);
    chk("rst1 rvalid", 32'(rvalid), 32'h0);
    chk("rst1 err", 32'(err), 32'h0);
    chk("rst1 data_out", 32'(data_out), 32'h0);
    chk("rst1 rdata", rdata, 32'h0);
    drive(32'h800, 32'h0, 1, 1, 1);
    chk("rst2 rvalid", 32'(rvalid), 32'h0);
    chk("rst2 err", 32'(err), 32'h0);
`ifdef DATA_MEM_CNT_EN
    drive(CNT_ADDR, 32'h0, 0, 1, 0);
    chk("post-rst cnt", rdata, 32'h0);
`else
    drive(32'h10, 32'h0, 0, 1, 0);
    chk("post-rst ram", rdata, 32'hDEAD_BEEF);
`endif
    chk("post-rst rvalid", 32'(rvalid), 32'h1);
    chk("post-rst data_out", 32'(data_out), 32'h0);
    drive(32'h0, 32'h0, 0, 0, 0);
    chk("idle rvalid", 32'(rvalid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
